// File: rtl/lcd_timing_gen.sv
// lcd_timing_gen: LCD hs/vs/de timing generator with a one-clk pixel request pipeline; define LCD_TEST_PATTERN_EN for colour-bar test pattern
module lcd_timing_gen #(
  parameter int H_SYNC  = 128,
  parameter int H_BACK  = 88,
  parameter int H_DISP  = 800,
  parameter int H_FRONT = 40,
  parameter int V_SYNC  = 2,
  parameter int V_BACK  = 33,
  parameter int V_DISP  = 480,
  parameter int V_FRONT = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        test_mode,
  input  logic [23:0] pixel_data,
  output logic [10:0] pixel_xpos,
  output logic [10:0] pixel_ypos,
  output logic        lcd_hs,
  output logic        lcd_vs,
  output logic        lcd_de,
  output logic [23:0] lcd_rgb,
  output logic        frame_start
);
  localparam logic [10:0] H_MAX = 11'(H_SYNC + H_BACK + H_DISP + H_FRONT - 1);
  localparam logic [10:0] H_HS  = 11'(H_SYNC);
  localparam logic [10:0] H_DE0 = 11'(H_SYNC + H_BACK);
  localparam logic [10:0] H_DE1 = 11'(H_SYNC + H_BACK + H_DISP);
  localparam logic [10:0] H_RQ0 = H_DE0 - 11'd1;
  localparam logic [10:0] H_RQ1 = H_DE1 - 11'd1;
  localparam logic [10:0] X_OFF = H_DE0 - 11'd2;
  localparam logic [10:0] V_MAX = 11'(V_SYNC + V_BACK + V_DISP + V_FRONT - 1);
  localparam logic [10:0] V_VS  = 11'(V_SYNC);
  localparam logic [10:0] V_DE0 = 11'(V_SYNC + V_BACK);
  localparam logic [10:0] V_DE1 = 11'(V_SYNC + V_BACK + V_DISP);
  localparam logic [10:0] Y_OFF = V_DE0 - 11'd1;
`ifdef LCD_TEST_PATTERN_EN
  localparam logic [10:0] BAR_W = 11'(H_DISP / 8);
  localparam logic [23:0] BARS [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                                       24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};
`else
  logic unused_test_mode;
  assign unused_test_mode = test_mode;
`endif
  logic        run_q, run_d;
  logic [10:0] h_q, h_d, v_q, v_d;
  logic        h_wrap, v_act;
  // next counters: held at 0 while disabled and on the first enabled clk, then advance
  always_comb begin
    h_wrap = h_q == H_MAX;
    run_d  = en;
    h_d    = (!en || !run_q || h_wrap) ? 11'd0 : h_q + 11'd1;
    v_d    = (!en || !run_q) ? 11'd0 : !h_wrap ? v_q : (v_q == V_MAX) ? 11'd0 : v_q + 11'd1;
  end
  // counter and run registers; rst wins over en
  always_ff @(posedge clk) begin
    if (rst) begin
      run_q <= 1'b0;
      h_q   <= 11'd0;
      v_q   <= 11'd0;
    end else begin
      run_q <= run_d;
      h_q   <= h_d;
      v_q   <= v_d;
    end
  end
  // outputs decoded from registered state only; pixel_data reaches lcd_rgb alone
  always_comb begin
    v_act       = run_q && v_q >= V_DE0 && v_q < V_DE1;
    lcd_hs      = !(run_q && h_q < H_HS);
    lcd_vs      = !(run_q && v_q < V_VS);
    lcd_de      = v_act && h_q >= H_DE0 && h_q < H_DE1;
    pixel_xpos  = (v_act && h_q >= H_RQ0 && h_q < H_RQ1) ? h_q - X_OFF : 11'd0;
    pixel_ypos  = v_act ? v_q - Y_OFF : 11'd0;
    frame_start = run_q && h_q == 11'd0 && v_q == 11'd0;
`ifdef LCD_TEST_PATTERN_EN
    lcd_rgb     = !lcd_de ? 24'h0 : test_mode ? BARS[3'((h_q - H_DE0) / BAR_W)] : pixel_data;
`else
    lcd_rgb     = lcd_de ? pixel_data : 24'h0;
`endif
  end
endmodule

// File: tb/tb_lcd_timing_gen.sv
// tb_lcd_timing_gen: table vectors plus per-clk scoreboard for lcd_timing_gen on a reduced raster
module tb_lcd_timing_gen;
  localparam int HS = 4, HB = 3, HD = 16, HF = 2, VS = 2, VB = 3, VD = 5, VF = 2;
  localparam int HT = HS + HB + HD + HF, VT = VS + VB + VD + VF, FT = HT * VT;
  logic        clk = 0, rst = 1, en = 0, test_mode = 0;
  logic [23:0] pixel_data = 0;
  logic [10:0] pixel_xpos, pixel_ypos;
  logic        lcd_hs, lcd_vs, lcd_de, frame_start;
  logic [23:0] lcd_rgb;
  typedef struct {logic hs, vs, de, fs; logic [10:0] x, y; logic [23:0] rgb;} exp_t;
  typedef struct {int v, h, hs, vs, de, fs, x, y;} vec_t;
  exp_t        sbq[$];
  vec_t        tbl[15];
  int          n_cmp = 0, n_bad = 0, m_t = 0;
  bit          m_run = 0, coord_mode = 1, agg_on = 0, got_first = 0;
  logic [10:0] m_x = 0, m_y = 0;
  logic [23:0] fixed_pd = 24'h123456, first_rgb = 0, last_rgb = 0;
  int          sc, hs_low, vs_low, de_n, fs_n, fs0, fs1;
  logic [23:0] bars [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                            24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

  lcd_timing_gen #(.H_SYNC(HS), .H_BACK(HB), .H_DISP(HD), .H_FRONT(HF),
                   .V_SYNC(VS), .V_BACK(VB), .V_DISP(VD), .V_FRONT(VF)) dut (
    .clk(clk), .rst(rst), .en(en), .test_mode(test_mode), .pixel_data(pixel_data),
    .pixel_xpos(pixel_xpos), .pixel_ypos(pixel_ypos), .lcd_hs(lcd_hs), .lcd_vs(lcd_vs),
    .lcd_de(lcd_de), .lcd_rgb(lcd_rgb), .frame_start(frame_start));

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    n_cmp++;
    if (a !== e) begin
      n_bad++;
      if (n_bad <= 40) $display("FAIL %s: got %0h expected %0h at %0t", nm, a, e, $time);
    end
  endtask

  function automatic exp_t model(input bit run, input int t, input logic [10:0] px, input logic [10:0] py);
    exp_t e;
    int h, v;
    bit va, pat;
    h = (t % FT) % HT;
    v = (t % FT) / HT;
    va = run && v >= VS + VB && v < VS + VB + VD;
    e.hs = !(run && h < HS);
    e.vs = !(run && v < VS);
    e.de = va && h >= HS + HB && h < HS + HB + HD;
    e.x = (va && h >= HS + HB - 1 && h < HS + HB + HD - 1) ? 11'(h - (HS + HB - 2)) : 11'd0;
    e.y = va ? 11'(v - (VS + VB - 1)) : 11'd0;
    e.fs = run && (t % FT) == 0;
    pat = 0;
`ifdef LCD_TEST_PATTERN_EN
    pat = test_mode;
`endif
    e.rgb = !e.de ? 24'h0 : pat ? bars[(h - HS - HB) / (HD / 8)] : coord_mode ? {2'b00, py, px} : fixed_pd;
    return e;
  endfunction

  task automatic step(input bit r, input bit e);
    exp_t x, a;
    @(negedge clk);
    pixel_data = coord_mode ? {2'b00, pixel_ypos, pixel_xpos} : fixed_pd;
    rst = r;
    en = e;
    if (r || !e) begin m_run = 0; m_t = 0; end
    else if (!m_run) begin m_run = 1; m_t = 0; end
    else m_t++;
    x = model(m_run, m_t, m_x, m_y);
    m_x = x.x;
    m_y = x.y;
    sbq.push_back(x);
    @(posedge clk);
    #1;
    a = sbq.pop_front();
    chk("hs", 32'(lcd_hs), 32'(a.hs));
    chk("vs", 32'(lcd_vs), 32'(a.vs));
    chk("de", 32'(lcd_de), 32'(a.de));
    chk("frame_start", 32'(frame_start), 32'(a.fs));
    chk("xpos", 32'(pixel_xpos), 32'(a.x));
    chk("ypos", 32'(pixel_ypos), 32'(a.y));
    chk("rgb", 32'(lcd_rgb), 32'(a.rgb));
    if (agg_on) begin
      if (!lcd_hs) hs_low++;
      if (!lcd_vs) vs_low++;
      if (lcd_de) begin
        de_n++;
        if (!got_first) begin first_rgb = lcd_rgb; got_first = 1; end
        if (sc < FT) last_rgb = lcd_rgb;
      end
      if (frame_start) begin
        if (fs_n == 0) fs0 = sc; else if (fs_n == 1) fs1 = sc;
        fs_n++;
      end
      sc++;
    end
  endtask

  initial begin
    tbl = '{'{0, 0, 0, 0, 0, 1, 0, 0}, '{0, 3, 0, 0, 0, 0, 0, 0}, '{0, 4, 1, 0, 0, 0, 0, 0},
            '{1, 24, 1, 0, 0, 0, 0, 0}, '{2, 0, 0, 1, 0, 0, 0, 0}, '{4, 7, 1, 1, 0, 0, 0, 0},
            '{5, 5, 1, 1, 0, 0, 0, 1}, '{5, 6, 1, 1, 0, 0, 1, 1}, '{5, 7, 1, 1, 1, 0, 2, 1},
            '{5, 21, 1, 1, 1, 0, 16, 1}, '{5, 22, 1, 1, 1, 0, 0, 1}, '{5, 23, 1, 1, 0, 0, 0, 1},
            '{9, 21, 1, 1, 1, 0, 16, 5}, '{10, 7, 1, 1, 0, 0, 0, 0}, '{11, 24, 1, 1, 0, 0, 0, 0}};
    for (int i = 0; i < 3; i++) step(1, 0);
    step(1, 1);
    {sc, hs_low, vs_low, de_n, fs_n, fs0, fs1} = '0;
    agg_on = 1;
    step(0, 1);
    for (int i = 0; i < 15; i++) begin
      for (int g = 0; g < FT && m_t != tbl[i].v * HT + tbl[i].h; g++) step(0, 1);
      chk("tbl_hs", 32'(lcd_hs), tbl[i].hs);
      chk("tbl_vs", 32'(lcd_vs), tbl[i].vs);
      chk("tbl_de", 32'(lcd_de), tbl[i].de);
      chk("tbl_fs", 32'(frame_start), tbl[i].fs);
      chk("tbl_xpos", 32'(pixel_xpos), tbl[i].x);
      chk("tbl_ypos", 32'(pixel_ypos), tbl[i].y);
    end
    for (int g = 0; g < 2 * FT && sc < 2 * FT; g++) step(0, 1);
    agg_on = 0;
    chk("frame_count", fs_n, 2);
    chk("frame_period", fs1 - fs0, FT);
    chk("hs_low_clks", hs_low, 2 * VT * HS);
    chk("vs_low_clks", vs_low, 2 * VS * HT);
    chk("de_clks", de_n, 2 * VD * HD);
    chk("first_pixel", 32'(first_rgb), {10'd0, 11'd1, 11'd1});
    chk("last_pixel", 32'(last_rgb), {10'd0, 11'(VD), 11'(HD)});
    for (int g = 0; g < FT && (m_t % FT) != 6 * HT + 10; g++) step(0, 1);
    for (int i = 0; i < 10; i++) step(0, 0);
    step(0, 1);
    chk("reen_frame_start", 32'(frame_start), 1);
    chk("reen_hs", 32'(lcd_hs), 0);
    for (int i = 0; i < HT + 12; i++) step(0, 1);
    for (int g = 0; g < HT && (m_t % HT) != 12; g++) step(0, 1);
    step(1, 1);
    chk("rst_pulse_hs", 32'(lcd_hs), 1);
    chk("rst_pulse_de", 32'(lcd_de), 0);
    step(0, 1);
    chk("rst_release_fs", 32'(frame_start), 1);
    coord_mode = 0;
    test_mode = 1;
    for (int i = 0; i < FT; i++) step(0, 1);
    test_mode = 0;
    for (int i = 0; i < FT; i++) step(0, 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
